// File: rtl/router_pkg.sv
// Shared router types, flit field layout and the XY routing / one-hot helpers.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

package router_pkg;

    typedef enum logic [1:0] {
        BODY      = 2'b00,
        HEAD      = 2'b01,
        TAIL      = 2'b10,
        HEAD_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        IDLE,
        ROUTING,
        VC_ALLOC,
        ACTIVE
    } vc_state_e;

    localparam int FLIT_TYPE_LSB = 0;
    localparam int FLIT_TYPE_W   = 2;

    localparam int unsigned PORT_N   = 0;
    localparam int unsigned PORT_S   = 1;
    localparam int unsigned PORT_W   = 2;
    localparam int unsigned PORT_E   = 3;
    localparam int unsigned PORT_L   = 4;
    localparam int          PORT_CNT = 5;

    function automatic logic [PORT_CNT-1:0] index_2_one_hot(input int unsigned idx);
        return PORT_CNT'(1) << idx;
    endfunction

    // X is resolved before Y; row index grows towards the S port.
    function automatic logic [PORT_CNT-1:0] route_compute(input int unsigned cur_id,
                                                          input int unsigned dst_id,
                                                          input int unsigned per_row);
        int unsigned cx, cy, dx, dy, port;
        cx = cur_id % per_row;
        cy = cur_id / per_row;
        dx = dst_id % per_row;
        dy = dst_id / per_row;
        if (dx > cx)      port = PORT_E;
        else if (dx < cx) port = PORT_W;
        else if (dy < cy) port = PORT_N;
        else if (dy > cy) port = PORT_S;
        else              port = PORT_L;
        return index_2_one_hot(port);
    endfunction

    function automatic logic is_head(input flit_type_e t);
        return (t == HEAD) || (t == HEAD_TAIL);
    endfunction

    function automatic logic is_tail(input flit_type_e t);
        return (t == TAIL) || (t == HEAD_TAIL);
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single-VC flit FIFO; any depth >= 2, pointers wrap explicitly at DEPTH-1.
module vc_fifo #(
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [FLIT_W-1:0]          din,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [FLIT_W-1:0]          front
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic              do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign front   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the same cycle frees a slot.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vc_input_unit.sv
// Router input port: per-VC FIFOs, packet FSMs, route compute and VA/SA handshakes.
// Each switched flit is registered to the crossbar and returns one upstream credit.
module vc_input_unit
    import router_pkg::*;
#(
    parameter int NUM_PORTS      = 5,
    parameter int NUM_VC         = 4,
    parameter int VC_DEPTH       = 4,
    parameter int FLIT_W         = `FLIT_DATA_WIDTH,
    parameter int NUM_ROUTERS    = 16,
    parameter int ROUTER_PER_ROW = 4,
    parameter int ROUTER_ID      = 0,
    parameter int VC_BITS        = $clog2(NUM_VC)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [FLIT_W-1:0]           in_flit,
    input  logic                        in_valid,
    input  logic [VC_BITS-1:0]          in_vc,
    output logic [NUM_VC-1:0]           va_req,
    output logic [NUM_PORTS*NUM_VC-1:0] va_dst_port,
    input  logic [NUM_VC-1:0]           va_grant,
    input  logic [VC_BITS*NUM_VC-1:0]   va_out_vc,
    input  logic [NUM_VC-1:0]           ds_credit_ok,
    output logic [NUM_VC-1:0]           sa_req,
    input  logic [NUM_VC-1:0]           sa_grant,
    output logic [FLIT_W-1:0]           st_flit,
    output logic                        st_valid,
    output logic [NUM_PORTS-1:0]        st_dst_port,
    output logic [VC_BITS-1:0]          st_out_vc,
    output logic                        credit_valid,
    output logic [VC_BITS-1:0]          credit_vc,
    output logic                        err_overflow,
    output logic                        err_protocol
);
    localparam int RID_BITS = $clog2(NUM_ROUTERS);
    localparam int CNT_W    = $clog2(VC_DEPTH + 1);

    vc_state_e            state_q    [NUM_VC];
    vc_state_e            state_d    [NUM_VC];
    logic [NUM_PORTS-1:0] port_q     [NUM_VC];
    logic [VC_BITS-1:0]   out_vc_q   [NUM_VC];
    logic [FLIT_W-1:0]    fifo_front [NUM_VC];
    logic [CNT_W-1:0]     fifo_count [NUM_VC];
    logic [NUM_VC-1:0]    fifo_push, fifo_pop, fifo_full, fifo_empty, proto_drop;
    logic                 sa_sel_valid;
    logic [VC_BITS-1:0]   sa_sel;
    logic                 overflow;

    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        vc_fifo #(.FLIT_W(FLIT_W), .DEPTH(VC_DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (fifo_push[g]),
            .pop   (fifo_pop[g]),
            .din   (in_flit),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g]),
            .count (fifo_count[g]),
            .front (fifo_front[g])
        );
    end

    always_comb begin
        fifo_push = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            fifo_push[v] = in_valid && (in_vc == VC_BITS'(v));
        end
    end

    assign overflow = in_valid && fifo_full[in_vc] && !fifo_pop[in_vc];

    always_comb begin
        state_d      = state_q;
        fifo_pop     = '0;
        proto_drop   = '0;
        va_req       = '0;
        va_dst_port  = '0;
        sa_req       = '0;
        sa_sel_valid = 1'b0;
        sa_sel       = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            case (state_q[v])
                IDLE: begin
                    if (!fifo_empty[v]) begin
                        if (is_head(flit_type_e'(fifo_front[v][FLIT_TYPE_LSB +: FLIT_TYPE_W]))) begin
                            state_d[v] = ROUTING;
                        end else begin
                            fifo_pop[v]   = 1'b1;
                            proto_drop[v] = 1'b1;
                        end
                    end
                end
                ROUTING:  state_d[v] = VC_ALLOC;
                VC_ALLOC: begin
                    va_req[v] = 1'b1;
                    va_dst_port[v*NUM_PORTS +: NUM_PORTS] = port_q[v];
                    if (va_grant[v]) state_d[v] = ACTIVE;
                end
                ACTIVE:   sa_req[v] = (fifo_count[v] != '0) && ds_credit_ok[v];
                default:  state_d[v] = IDLE;
            endcase
        end
        // Lowest requesting VC wins a multi-hot grant; one switch pop per cycle.
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            if (!sa_sel_valid && sa_req[v] && sa_grant[v]) begin
                sa_sel_valid = 1'b1;
                sa_sel       = VC_BITS'(v);
            end
        end
        if (sa_sel_valid) begin
            fifo_pop[sa_sel] = 1'b1;
            if (is_tail(flit_type_e'(fifo_front[sa_sel][FLIT_TYPE_LSB +: FLIT_TYPE_W]))) begin
                state_d[sa_sel] = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned v = 0; v < NUM_VC; v++) state_q[v] <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                port_q[v]   <= '0;
                out_vc_q[v] <= '0;
            end
            st_flit      <= '0;
            st_valid     <= 1'b0;
            st_dst_port  <= '0;
            st_out_vc    <= '0;
            credit_valid <= 1'b0;
            credit_vc    <= '0;
            err_overflow <= 1'b0;
            err_protocol <= 1'b0;
        end else begin
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                if (state_q[v] == ROUTING) begin
                    port_q[v] <= NUM_PORTS'(route_compute(ROUTER_ID,
                                     32'(fifo_front[v][FLIT_W-1 -: RID_BITS]), ROUTER_PER_ROW));
                end
                if (state_q[v] == VC_ALLOC && va_grant[v]) begin
                    out_vc_q[v] <= va_out_vc[v*VC_BITS +: VC_BITS];
                end
            end
            st_valid     <= sa_sel_valid;
            credit_valid <= sa_sel_valid;
            if (sa_sel_valid) begin
                st_flit     <= fifo_front[sa_sel];
                st_dst_port <= port_q[sa_sel];
                st_out_vc   <= out_vc_q[sa_sel];
                credit_vc   <= sa_sel;
            end
            if (overflow)    err_overflow <= 1'b1;
            if (|proto_drop) err_protocol <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vc_input_unit.sv
// Directed bench for vc_input_unit: switched flits are predicted into a scoreboard
// at grant time and matched against st_* / credit_* one cycle later.
module tb_vc_input_unit;
    import router_pkg::*;

    localparam int NUM_PORTS = 5;
    localparam int NUM_VC    = 4;
    localparam int VC_BITS   = 2;
    localparam int FLIT_W    = 32;

    localparam logic [NUM_PORTS-1:0] P_E = 5'b01000;
    localparam logic [NUM_PORTS-1:0] P_L = 5'b10000;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [FLIT_W-1:0]           in_flit;
    logic                        in_valid;
    logic [VC_BITS-1:0]          in_vc;
    logic [NUM_VC-1:0]           va_req;
    logic [NUM_PORTS*NUM_VC-1:0] va_dst_port;
    logic [NUM_VC-1:0]           va_grant;
    logic [VC_BITS*NUM_VC-1:0]   va_out_vc;
    logic [NUM_VC-1:0]           ds_credit_ok;
    logic [NUM_VC-1:0]           sa_req;
    logic [NUM_VC-1:0]           sa_grant;
    logic [FLIT_W-1:0]           st_flit;
    logic                        st_valid;
    logic [NUM_PORTS-1:0]        st_dst_port;
    logic [VC_BITS-1:0]          st_out_vc;
    logic                        credit_valid;
    logic [VC_BITS-1:0]          credit_vc;
    logic                        err_overflow;
    logic                        err_protocol;

    vc_input_unit #(.NUM_PORTS(NUM_PORTS), .NUM_VC(NUM_VC), .VC_DEPTH(4), .FLIT_W(FLIT_W),
                    .NUM_ROUTERS(16), .ROUTER_PER_ROW(4), .ROUTER_ID(0)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .in_flit      (in_flit),
        .in_valid     (in_valid),
        .in_vc        (in_vc),
        .va_req       (va_req),
        .va_dst_port  (va_dst_port),
        .va_grant     (va_grant),
        .va_out_vc    (va_out_vc),
        .ds_credit_ok (ds_credit_ok),
        .sa_req       (sa_req),
        .sa_grant     (sa_grant),
        .st_flit      (st_flit),
        .st_valid     (st_valid),
        .st_dst_port  (st_dst_port),
        .st_out_vc    (st_out_vc),
        .credit_valid (credit_valid),
        .credit_vc    (credit_vc),
        .err_overflow (err_overflow),
        .err_protocol (err_protocol)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [FLIT_W-1:0]    flit;
        logic [NUM_PORTS-1:0] port;
        logic [VC_BITS-1:0]   ovc;
        logic [VC_BITS-1:0]   cvc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_st    = 0;
    int   n_exp   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FLIT_W-1:0] mk(input logic [3:0] dest, input logic [25:0] pay,
                                             input flit_type_e t);
        return {dest, pay, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int vc, input logic [FLIT_W-1:0] f);
        in_valid = 1'b1;
        in_vc    = VC_BITS'(vc);
        in_flit  = f;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_va(input int vc);
        int k = 0;
        while (va_req[vc] !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        chk($sformatf("va_req_vc%0d", vc), 64'(va_req[vc]), 64'(1));
    endtask

    task automatic grant_va(input int vc, input int ovc);
        wait_va(vc);
        va_grant[vc] = 1'b1;
        va_out_vc[vc*VC_BITS +: VC_BITS] = VC_BITS'(ovc);
        tick();
        va_grant = '0;
    endtask

    task automatic sa_pop(input logic [NUM_VC-1:0] gnt, input int vc, input logic [FLIT_W-1:0] f,
                          input logic [NUM_PORTS-1:0] port, input int ovc);
        exp_t e;
        chk($sformatf("sa_req_vc%0d", vc), 64'(sa_req[vc]), 64'(1));
        e.flit = f;
        e.port = port;
        e.ovc  = VC_BITS'(ovc);
        e.cvc  = VC_BITS'(vc);
        sb.push_back(e);
        n_exp++;
        sa_grant = gnt;
        tick();
        sa_grant = '0;
    endtask

    // Switch-traversal monitor: every st_valid/credit_valid must match a prediction.
    always @(posedge clk) begin
        #1;
        if (st_valid !== 1'b0 || credit_valid !== 1'b0) begin
            chk("credit_with_st", 64'(credit_valid), 64'(st_valid));
            if (sb.size() == 0) begin
                chk("st_unexpected", 64'(st_valid), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                n_st++;
                chk("st_flit", 64'(st_flit), 64'(mon_e.flit));
                chk("st_dst_port", 64'(st_dst_port), 64'(mon_e.port));
                chk("st_out_vc", 64'(st_out_vc), 64'(mon_e.ovc));
                chk("credit_vc", 64'(credit_vc), 64'(mon_e.cvc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [FLIT_W-1:0]           f, h, b1, b2, b3, t, h0, t0, h1, t1;
        logic [NUM_PORTS*NUM_VC-1:0] exp_dst;

        reset = 1'b0; in_flit = '0; in_valid = 1'b0; in_vc = '0; va_grant = '0;
        va_out_vc = '0; ds_credit_ok = '0; sa_grant = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_st_valid", 64'(st_valid), 64'(0));
        chk("rst_credit_valid", 64'(credit_valid), 64'(0));
        chk("rst_va_req", 64'(va_req), 64'(0));
        chk("rst_sa_req", 64'(sa_req), 64'(0));
        chk("rst_err", 64'({err_overflow, err_protocol}), 64'(0));
        #2 reset = 1'b1;
        tick();

        // 1: single-flit packet to VC2 routed east, out VC 3
        ds_credit_ok = '1;
        f = mk(4'd3, 26'h00A1, HEAD_TAIL);
        send(2, f);
        wait_va(2);
        exp_dst = 20'(P_E) << 10;
        chk("t1_va_dst", 64'(va_dst_port), 64'(exp_dst));
        chk("t1_sa_req_alloc", 64'(sa_req), 64'(0));
        va_grant[3] = 1'b1;
        va_out_vc[7:6] = 2'd1;
        tick();
        va_grant = '0;
        chk("t1_va_hold", 64'(va_req), 64'(4'b0100));
        chk("t1_vc3_ignores_grant", 64'(u_dut.state_q[3]), 64'(IDLE));
        tick();
        chk("t1_va_dst_hold", 64'(va_dst_port), 64'(exp_dst));
        va_grant[2] = 1'b1;
        va_out_vc[5:4] = 2'd3;
        tick();
        va_grant = '0;
        chk("t1_va_req_off", 64'(va_req), 64'(0));
        sa_pop(4'b0100, 2, f, P_E, 3);
        chk("t1_vc2_idle", 64'(u_dut.state_q[2]), 64'(IDLE));
        tick();
        chk("t1_st_once", 64'(st_valid), 64'(0));
        chk("t1_sb_drain", 64'(sb.size()), 64'(0));

        // 2: H,B,B,T to VC0, ejected locally, switched back to back
        h = mk(4'd0, 26'h0101, HEAD); b1 = mk(4'd0, 26'h0102, BODY);
        b2 = mk(4'd0, 26'h0103, BODY); t = mk(4'd0, 26'h0104, TAIL);
        send(0, h); send(0, b1); send(0, b2); send(0, t);
        grant_va(0, 1);
        sa_pop(4'b0001, 0, h, P_L, 1);
        sa_pop(4'b0001, 0, b1, P_L, 1);
        sa_pop(4'b0001, 0, b2, P_L, 1);
        sa_pop(4'b0001, 0, t, P_L, 1);
        chk("t2_vc0_idle", 64'(u_dut.state_q[0]), 64'(IDLE));
        tick();
        chk("t2_sa_req_off", 64'(sa_req), 64'(0));
        chk("t2_sb_drain", 64'(sb.size()), 64'(0));

        // 3: overflow on VC1, then a full-FIFO write accepted alongside a pop
        h = mk(4'd1, 26'h0201, HEAD); b1 = mk(4'd1, 26'h0202, BODY);
        b2 = mk(4'd1, 26'h0203, BODY); b3 = mk(4'd1, 26'h0204, BODY);
        t = mk(4'd1, 26'h0205, TAIL);
        send(1, h); send(1, b1); send(1, b2); send(1, b3);
        chk("t3_count_full", 64'(u_dut.fifo_count[1]), 64'(4));
        chk("t3_no_ovf_yet", 64'(err_overflow), 64'(0));
        send(1, mk(4'd1, 26'h0DEAD, BODY));
        chk("t3_err_overflow", 64'(err_overflow), 64'(1));
        chk("t3_count_after_drop", 64'(u_dut.fifo_count[1]), 64'(4));
        grant_va(1, 2);
        in_valid = 1'b1; in_vc = 2'd1; in_flit = t;
        sa_pop(4'b0010, 1, h, P_E, 2);
        in_valid = 1'b0;
        chk("t3_count_push_pop", 64'(u_dut.fifo_count[1]), 64'(4));
        sa_pop(4'b0010, 1, b1, P_E, 2);
        sa_pop(4'b0010, 1, b2, P_E, 2);
        sa_pop(4'b0010, 1, b3, P_E, 2);
        sa_pop(4'b0010, 1, t, P_E, 2);
        chk("t3_vc1_idle", 64'(u_dut.state_q[1]), 64'(IDLE));
        chk("t3_count_empty", 64'(u_dut.fifo_count[1]), 64'(0));

        // 4: BODY at the front of an IDLE VC is discarded without a credit
        chk("t4_no_proto_yet", 64'(err_protocol), 64'(0));
        send(3, mk(4'd2, 26'h0301, BODY));
        chk("t4_proto_not_early", 64'(err_protocol), 64'(0));
        tick();
        chk("t4_err_protocol", 64'(err_protocol), 64'(1));
        chk("t4_vc3_idle", 64'(u_dut.state_q[3]), 64'(IDLE));
        chk("t4_vc3_count", 64'(u_dut.fifo_count[3]), 64'(0));
        chk("t4_no_credit", 64'(credit_valid), 64'(0));
        chk("t4_sb_drain", 64'(sb.size()), 64'(0));

        // 5: credit gating and lowest-index pick on a multi-hot grant
        ds_credit_ok = 4'b1101;
        h0 = mk(4'd2, 26'h0401, HEAD); h1 = mk(4'd0, 26'h0402, HEAD);
        t0 = mk(4'd2, 26'h0403, TAIL); t1 = mk(4'd0, 26'h0404, TAIL);
        send(0, h0); send(1, h1); send(0, t0); send(1, t1);
        grant_va(0, 2);
        grant_va(1, 0);
        chk("t5_sa_req_gated", 64'(sa_req), 64'(4'b0001));
        ds_credit_ok = '1;
        #1;
        chk("t5_sa_req_both", 64'(sa_req), 64'(4'b0011));
        sa_pop(4'b0011, 0, h0, P_E, 2);
        sa_pop(4'b0011, 0, t0, P_E, 2);
        sa_pop(4'b0011, 1, h1, P_L, 0);
        sa_pop(4'b0011, 1, t1, P_L, 0);
        tick();
        chk("t5_sb_drain", 64'(sb.size()), 64'(0));

        // 6: asynchronous reset in the middle of a packet
        h = mk(4'd2, 26'h0501, HEAD); b1 = mk(4'd2, 26'h0502, BODY); b2 = mk(4'd2, 26'h0503, BODY);
        send(0, h); send(0, b1); send(0, b2);
        grant_va(0, 3);
        sa_pop(4'b0001, 0, h, P_E, 3);
        chk("t6_st_before_reset", 64'(st_valid), 64'(1));
        #1 reset = 1'b0;
        #1;
        chk("t6_rst_st_valid", 64'(st_valid), 64'(0));
        chk("t6_rst_credit", 64'(credit_valid), 64'(0));
        chk("t6_rst_st_port", 64'(st_dst_port), 64'(0));
        chk("t6_rst_reqs", 64'({va_req, sa_req}), 64'(0));
        chk("t6_rst_err", 64'({err_overflow, err_protocol}), 64'(0));
        #2 reset = 1'b1;
        tick();
        tick();
        for (int v = 0; v < NUM_VC; v++) begin
            chk($sformatf("t6_vc%0d_idle", v), 64'(u_dut.state_q[v]), 64'(IDLE));
            chk($sformatf("t6_vc%0d_count", v), 64'(u_dut.fifo_count[v]), 64'(0));
        end
        chk("t6_sa_req_off", 64'(sa_req), 64'(0));
        chk("t6_st_quiet", 64'(st_valid), 64'(0));

        tick();
        chk("end_sb_drain", 64'(sb.size()), 64'(0));
        chk("end_st_total", 64'(n_st), 64'(n_exp));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
